// File: rtl/adc_capture_buffer_x4ch.sv
// adc_capture_buffer_x4ch
//
// Captures a triggered window of DEPTH = 2^ADDR_W samples from the four
// deserialized ADC channels (A-D) into block RAM. PRETRIG samples ahead of
// the trigger are kept. The window is then streamed out one channel word at
// a time over a valid/ready interface.
//
// Ports:
//   GCLK          deserializer parallel clock, the only clock
//   RESET         synchronous, active-high reset
//   DCHAIN..DCHDIN  channel A..D sample words, one new sample per GCLK
//   ARM           pulse, starts a capture when idle
//   TRIG          trigger level; the first qualifying cycle in WAIT_TRIG counts
//   RD_START      pulse, starts readout of a completed window
//   DOUT          readout word (sample0 A,B,C,D, sample1 A,B,C,D, ...)
//   DOUT_VALID    DOUT holds a word
//   DOUT_READY    consumer accepts DOUT
//   DOUT_LAST     DOUT is the final word of the window
//   BUSY          capture in progress (accepted ARM until window complete)
//   DONE          window captured and not yet fully read
//   TRIG_ADDR     RAM address that holds the trigger sample

module adc_capture_buffer_x4ch #(
  parameter int ADDR_W  = 10,
  parameter int PRETRIG = 256,
  parameter int DW      = 16
) (
  input  logic              GCLK,
  input  logic              RESET,
  input  logic [DW-1:0]     DCHAIN,
  input  logic [DW-1:0]     DCHBIN,
  input  logic [DW-1:0]     DCHCIN,
  input  logic [DW-1:0]     DCHDIN,
  input  logic              ARM,
  input  logic              TRIG,
  input  logic              RD_START,
  output logic [DW-1:0]     DOUT,
  output logic              DOUT_VALID,
  input  logic              DOUT_READY,
  output logic              DOUT_LAST,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] TRIG_ADDR
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int POST_N = DEPTH - PRETRIG - 1;

  localparam logic [ADDR_W-1:0] A_ONE     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PRE_LEN   = ADDR_W'(PRETRIG);
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRETRIG - 1);
  localparam logic [ADDR_W-1:0] POST_LEN  = ADDR_W'(POST_N);
  localparam logic [ADDR_W-1:0] RD_REMAIN = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W+1:0] W_ONE     = (ADDR_W+2)'(1);
  localparam logic [ADDR_W+1:0] LAST_WORD = (ADDR_W+2)'(4*DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    WAIT_TRIG,
    POST,
    DONE_ST,
    READOUT
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wp_q, wp_d;
  logic [ADDR_W-1:0]   pre_cnt_q, pre_cnt_d;
  logic [ADDR_W-1:0]   post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]   rd_left_q, rd_left_d;
  logic                buf_valid_q, buf_valid_d;
  logic [1:0]          ch_idx_q, ch_idx_d;
  logic [ADDR_W+1:0]   wcnt_q, wcnt_d;
  logic [DW-1:0]       dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;
  logic                dout_last_q, dout_last_d;

  logic                mem_we;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic [4*DW-1:0]     wr_word;
  logic [4*DW-1:0]     rd_word_q;
  logic [DW-1:0]       chan_word;

  logic [4*DW-1:0]     mem [DEPTH];

  // All four channels of a sample share one RAM word so they can never skew.
  assign wr_word = {DCHDIN, DCHCIN, DCHBIN, DCHAIN};

  // Sample RAM with a registered read port. No reset here so it maps onto
  // block RAM; contents after reset are meaningless until rewritten.
  always_ff @(posedge GCLK) begin
    if (mem_we) begin
      mem[wp_q] <= wr_word;
    end
    if (rd_en) begin
      rd_word_q <= mem[rd_addr];
    end
  end

  // Picks the channel of the buffered sample that goes out next (A first).
  always_comb begin
    chan_word = rd_word_q[DW-1:0];
    case (ch_idx_q)
      2'd1:    chan_word = rd_word_q[2*DW-1:DW];
      2'd2:    chan_word = rd_word_q[3*DW-1:2*DW];
      2'd3:    chan_word = rd_word_q[4*DW-1:3*DW];
      default: chan_word = rd_word_q[DW-1:0];
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge GCLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      wp_q         <= '0;
      pre_cnt_q    <= '0;
      post_cnt_q   <= '0;
      trig_addr_q  <= '0;
      rd_addr_q    <= '0;
      rd_left_q    <= '0;
      buf_valid_q  <= 1'b0;
      ch_idx_q     <= '0;
      wcnt_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wp_q         <= wp_d;
      pre_cnt_q    <= pre_cnt_d;
      post_cnt_q   <= post_cnt_d;
      trig_addr_q  <= trig_addr_d;
      rd_addr_q    <= rd_addr_d;
      rd_left_q    <= rd_left_d;
      buf_valid_q  <= buf_valid_d;
      ch_idx_q     <= ch_idx_d;
      wcnt_q       <= wcnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
    end
  end

  // Next-state and datapath control.
  // Readout keeps one RAM sample buffered in rd_word_q and feeds its four
  // channels into the output register. The next sample is fetched in the
  // same cycle the last channel moves out, so READY held high gives one word
  // per cycle with no bubble between samples.
  always_comb begin
    state_d      = state_q;
    wp_d         = wp_q;
    pre_cnt_d    = pre_cnt_q;
    post_cnt_d   = post_cnt_q;
    trig_addr_d  = trig_addr_q;
    rd_addr_d    = rd_addr_q;
    rd_left_d    = rd_left_q;
    buf_valid_d  = buf_valid_q;
    ch_idx_d     = ch_idx_q;
    wcnt_d       = wcnt_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    dout_last_d  = dout_last_q;
    mem_we       = 1'b0;
    rd_en        = 1'b0;
    rd_addr      = rd_addr_q;

    case (state_q)
      IDLE: begin
        if (ARM) begin
          pre_cnt_d = '0;
          state_d   = (PRETRIG == 0) ? WAIT_TRIG : FILL;
        end
      end

      FILL: begin
        mem_we    = 1'b1;
        pre_cnt_d = pre_cnt_q + A_ONE;
        if (pre_cnt_q == PRE_LAST) begin
          state_d = WAIT_TRIG;
        end
      end

      WAIT_TRIG: begin
        mem_we = 1'b1;
        if (TRIG) begin
          trig_addr_d = wp_q;
          post_cnt_d  = POST_LEN;
          state_d     = (POST_N == 0) ? DONE_ST : POST;
        end
      end

      POST: begin
        mem_we     = 1'b1;
        post_cnt_d = post_cnt_q - A_ONE;
        if (post_cnt_q == A_ONE) begin
          state_d = DONE_ST;
        end
      end

      DONE_ST: begin
        if (RD_START) begin
          state_d     = READOUT;
          rd_en       = 1'b1;
          rd_addr     = trig_addr_q - PRE_LEN;
          rd_addr_d   = rd_addr + A_ONE;
          rd_left_d   = RD_REMAIN;
          buf_valid_d = 1'b1;
          ch_idx_d    = '0;
          wcnt_d      = '0;
        end
      end

      READOUT: begin
        if (dout_valid_q && DOUT_READY) begin
          dout_valid_d = 1'b0;
          dout_last_d  = 1'b0;
          if (dout_last_q) begin
            state_d = IDLE;
          end
        end
        if (buf_valid_q && (!dout_valid_q || DOUT_READY)) begin
          dout_d       = chan_word;
          dout_valid_d = 1'b1;
          dout_last_d  = (wcnt_q == LAST_WORD);
          wcnt_d       = wcnt_q + W_ONE;
          ch_idx_d     = ch_idx_q + 2'd1;
          if (ch_idx_q == 2'd3) begin
            if (rd_left_q != '0) begin
              rd_en     = 1'b1;
              rd_addr_d = rd_addr_q + A_ONE;
              rd_left_d = rd_left_q - A_ONE;
            end else begin
              buf_valid_d = 1'b0;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (mem_we) begin
      wp_d = wp_q + A_ONE;
    end
  end

  assign DOUT       = dout_q;
  assign DOUT_VALID = dout_valid_q;
  assign DOUT_LAST  = dout_last_q;
  assign TRIG_ADDR  = trig_addr_q;
  assign BUSY       = (state_q == FILL) || (state_q == WAIT_TRIG) || (state_q == POST);
  assign DONE       = (state_q == DONE_ST) || (state_q == READOUT);

endmodule

// File: tb/tb_adc_capture_buffer_x4ch.sv
// tb_adc_capture_buffer_x4ch
//
// Drives three builds of the capture buffer (DEPTH=16 with PRETRIG = 4, 0
// and 15) from a shared counting data source: A=n, B=n+0x1000, C=n+0x2000,
// D=n+0x3000. "n" is the sample presented during the current cycle; ARM is
// registered, so a capture whose first stored sample is N is armed while
// N-1 is on the inputs.

module tb_adc_capture_buffer_x4ch;

  localparam int ADDR_W = 4;
  localparam int DW     = 16;
  localparam int WORDS  = 64;

  logic              GCLK = 1'b0;
  logic              RESET;
  logic [DW-1:0]     da, db, dc, dd;
  logic              arm [3];
  logic              trig [3];
  logic              rd_start [3];
  logic              rdy [3];
  logic [DW-1:0]     dout [3];
  logic              dout_valid [3];
  logic              dout_last [3];
  logic              busy [3];
  logic              done [3];
  logic [ADDR_W-1:0] trig_addr [3];

  int n;
  int compared   = 0;
  int mismatched = 0;

  always #5 GCLK = ~GCLK;

  adc_capture_buffer_x4ch #(.ADDR_W(ADDR_W), .PRETRIG(4), .DW(DW)) u_pre4 (
    .GCLK(GCLK), .RESET(RESET),
    .DCHAIN(da), .DCHBIN(db), .DCHCIN(dc), .DCHDIN(dd),
    .ARM(arm[0]), .TRIG(trig[0]), .RD_START(rd_start[0]),
    .DOUT(dout[0]), .DOUT_VALID(dout_valid[0]), .DOUT_READY(rdy[0]),
    .DOUT_LAST(dout_last[0]), .BUSY(busy[0]), .DONE(done[0]),
    .TRIG_ADDR(trig_addr[0])
  );

  adc_capture_buffer_x4ch #(.ADDR_W(ADDR_W), .PRETRIG(0), .DW(DW)) u_pre0 (
    .GCLK(GCLK), .RESET(RESET),
    .DCHAIN(da), .DCHBIN(db), .DCHCIN(dc), .DCHDIN(dd),
    .ARM(arm[1]), .TRIG(trig[1]), .RD_START(rd_start[1]),
    .DOUT(dout[1]), .DOUT_VALID(dout_valid[1]), .DOUT_READY(rdy[1]),
    .DOUT_LAST(dout_last[1]), .BUSY(busy[1]), .DONE(done[1]),
    .TRIG_ADDR(trig_addr[1])
  );

  adc_capture_buffer_x4ch #(.ADDR_W(ADDR_W), .PRETRIG(15), .DW(DW)) u_pre15 (
    .GCLK(GCLK), .RESET(RESET),
    .DCHAIN(da), .DCHBIN(db), .DCHCIN(dc), .DCHDIN(dd),
    .ARM(arm[2]), .TRIG(trig[2]), .RD_START(rd_start[2]),
    .DOUT(dout[2]), .DOUT_VALID(dout_valid[2]), .DOUT_READY(rdy[2]),
    .DOUT_LAST(dout_last[2]), .BUSY(busy[2]), .DONE(done[2]),
    .TRIG_ADDR(trig_addr[2])
  );

  // Counts one comparison and reports it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (n=%0d)", tag, got, exp, n);
    end
  endtask

  task automatic drive_data();
    da = DW'(n);
    db = DW'(n + 'h1000);
    dc = DW'(n + 'h2000);
    dd = DW'(n + 'h3000);
  endtask

  // Lets one clock edge pass, then presents the next counter sample.
  task automatic applyStimulus();
    @(posedge GCLK);
    #1;
    n = n + 1;
    drive_data();
  endtask

  task automatic advance_to(input int target);
    while (n < target) applyStimulus();
  endtask

  task automatic pulse_arm(input int i);
    arm[i] = 1'b1;
    applyStimulus();
    arm[i] = 1'b0;
  endtask

  task automatic pulse_trig(input int i);
    trig[i] = 1'b1;
    applyStimulus();
    trig[i] = 1'b0;
  endtask

  // Resets all builds and restarts the data counter at zero.
  task automatic do_reset();
    for (int i = 0; i < 3; i++) begin
      arm[i] = 1'b0; trig[i] = 1'b0; rd_start[i] = 1'b0; rdy[i] = 1'b0;
    end
    RESET = 1'b1;
    applyStimulus();
    applyStimulus();
    RESET = 1'b0;
    n = 0;
    drive_data();
  endtask

  task automatic check_cleared(input int i, input string tag);
    checkOutput({tag, "_dout"},      dout[i], 0);
    checkOutput({tag, "_valid"},     dout_valid[i], 0);
    checkOutput({tag, "_last"},      dout_last[i], 0);
    checkOutput({tag, "_busy"},      busy[i], 0);
    checkOutput({tag, "_done"},      done[i], 0);
    checkOutput({tag, "_trig_addr"}, trig_addr[i], 0);
  endtask

  // Expected readout word k of a window whose first sample is start_n.
  function automatic logic [DW-1:0] exp_word(input int start_n, input int k);
    return DW'(start_n + k / 4 + (k % 4) * 'h1000);
  endfunction

  // Reads a full window. With stall set, READY follows 1,0,0,1 repeating;
  // every stalled cycle must leave DOUT/DOUT_LAST unchanged next cycle.
  task automatic read_window(input int i, input int start_n, input bit stall);
    int k = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [DW-1:0] held_d = '0;
    logic held_l = 1'b0;
    rdy[i] = 1'b1;
    rd_start[i] = 1'b1;
    applyStimulus();
    rd_start[i] = 1'b0;
    checkOutput("rd_latency_early", dout_valid[i], 0);
    applyStimulus();
    while (k < WORDS && cyc < 400) begin
      checkOutput("rd_valid", dout_valid[i], 1);
      if (stalled) begin
        checkOutput("stall_dout", dout[i], held_d);
        checkOutput("stall_last", dout_last[i], held_l);
      end
      rdy[i] = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      stalled = 1'b0;
      if (dout_valid[i] && rdy[i]) begin
        checkOutput("rd_word", dout[i], exp_word(start_n, k));
        checkOutput("rd_last", dout_last[i], (k == WORDS - 1));
        k++;
      end else if (dout_valid[i]) begin
        stalled = 1'b1;
        held_d  = dout[i];
        held_l  = dout_last[i];
      end
      applyStimulus();
      cyc++;
    end
    checkOutput("rd_word_count", k, WORDS);
    checkOutput("rd_end_valid", dout_valid[i], 0);
    checkOutput("rd_end_done", done[i], 0);
    rdy[i] = 1'b0;
  endtask

  initial begin
    n = 0;
    drive_data();
    RESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      arm[i] = 1'b0; trig[i] = 1'b0; rd_start[i] = 1'b0; rdy[i] = 1'b0;
    end

    // Basic capture, TRIG during POST and ARM during DONE_ST ignored.
    do_reset();
    check_cleared(0, "reset");
    advance_to(9);
    pulse_arm(0);
    checkOutput("s1_busy_after_arm", busy[0], 1);
    checkOutput("s1_done_after_arm", done[0], 0);
    advance_to(30);
    pulse_trig(0);
    checkOutput("s1_trig_addr", trig_addr[0], 4);
    advance_to(35);
    pulse_trig(0);
    advance_to(41);
    checkOutput("s1_busy_before_end", busy[0], 1);
    applyStimulus();
    checkOutput("s1_busy_end", busy[0], 0);
    checkOutput("s1_done_end", done[0], 1);
    checkOutput("s1_trig_addr_post", trig_addr[0], 4);
    pulse_arm(0);
    applyStimulus();
    checkOutput("s1_arm_in_done_busy", busy[0], 0);
    checkOutput("s1_arm_in_done_done", done[0], 1);
    checkOutput("s1_arm_in_done_taddr", trig_addr[0], 4);
    read_window(0, 26, 1'b0);

    // TRIG held high from ARM; only WAIT_TRIG honours it. Stalled readout.
    do_reset();
    advance_to(9);
    arm[0] = 1'b1;
    trig[0] = 1'b1;
    applyStimulus();
    arm[0] = 1'b0;
    advance_to(15);
    trig[0] = 1'b0;
    checkOutput("s2_trig_addr", trig_addr[0], 4);
    advance_to(26);
    checkOutput("s2_done", done[0], 1);
    read_window(0, 10, 1'b1);

    // RESET in the middle of POST, then a fresh capture.
    do_reset();
    advance_to(9);
    pulse_arm(0);
    advance_to(20);
    pulse_trig(0);
    checkOutput("s3_trig_addr_first", trig_addr[0], 10);
    advance_to(25);
    RESET = 1'b1;
    applyStimulus();
    RESET = 1'b0;
    check_cleared(0, "s3_midpost");
    advance_to(39);
    pulse_arm(0);
    advance_to(47);
    pulse_trig(0);
    advance_to(59);
    checkOutput("s3_done", done[0], 1);
    checkOutput("s3_trig_addr", trig_addr[0], 7);
    read_window(0, 43, 1'b0);

    // PRETRIG=0: trigger is the first word; write pointer wraps many times.
    do_reset();
    check_cleared(1, "p0_reset");
    advance_to(2);
    pulse_trig(1);
    checkOutput("p0_trig_idle_busy", busy[1], 0);
    advance_to(4);
    pulse_arm(1);
    checkOutput("p0_busy", busy[1], 1);
    advance_to(100);
    pulse_trig(1);
    checkOutput("p0_trig_addr", trig_addr[1], 15);
    advance_to(116);
    checkOutput("p0_done", done[1], 1);
    checkOutput("p0_busy_end", busy[1], 0);
    read_window(1, 100, 1'b0);

    // PRETRIG=15: trigger is the last sample, DONE immediately after it.
    do_reset();
    advance_to(4);
    pulse_arm(2);
    advance_to(100);
    checkOutput("p15_busy", busy[2], 1);
    pulse_trig(2);
    checkOutput("p15_busy_end", busy[2], 0);
    checkOutput("p15_done", done[2], 1);
    checkOutput("p15_trig_addr", trig_addr[2], 15);
    read_window(2, 85, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/adc_capture_buffer_x4ch.md
Name: adc_capture_buffer_x4ch

Overview:
- Consumes the four 16-bit deserialized ADC channel words (A–D) produced each GCLK cycle by the 4-channel deserializer.
- Captures a triggered window of 2^ADDR_W samples per channel into block RAM, with a programmable pre-trigger depth.
- Streams the window out through a valid/ready word interface to the readout/DMA logic.

Parameters:
ADDR_W, 10, log2 of capture depth; DEPTH = 2^ADDR_W samples per channel.
PRETRIG, 256, samples stored before the trigger sample; legal range 0..DEPTH-1.
DW, 16, channel word width.

Ports:
GCLK  in  1  deserializer parallel clock; the only clock.
RESET  in  1  synchronous, active-high reset.
DCHAIN  in  DW  channel A sample, new word every GCLK.
DCHBIN  in  DW  channel B sample.
DCHCIN  in  DW  channel C sample.
DCHDIN  in  DW  channel D sample.
ARM  in  1  single-cycle pulse; starts a capture when idle.
TRIG  in  1  trigger; sampled level, first qualifying cycle counts.
RD_START  in  1  pulse; starts readout when DONE.
DOUT  out  DW  readout word.
DOUT_VALID  out  1  DOUT valid.
DOUT_READY  in  1  consumer accepts DOUT.
DOUT_LAST  out  1  marks the final word of the window.
BUSY  out  1  high from accepted ARM until the window is complete.
DONE  out  1  window captured and not yet fully read.
TRIG_ADDR  out  ADDR_W  RAM address of the trigger sample.

Behaviour:
- Reset: state IDLE; DOUT=0, DOUT_VALID=0, DOUT_LAST=0, BUSY=0, DONE=0, TRIG_ADDR=0; write pointer and counters cleared. RESET mid-operation aborts capture or readout immediately. RAM contents are don't-care.
- RAM: DEPTH x 4*DW. One write per cycle in FILL, WAIT_TRIG and POST; the write pointer increments mod DEPTH.
- IDLE:
  - ARM -> FILL; clear pre-count; BUSY=1 next cycle.
  - TRIG in IDLE is ignored, including TRIG in the same cycle as ARM.
- FILL:
  - Write each cycle; pre-count++.
  - When pre-count reaches PRETRIG -> WAIT_TRIG. If PRETRIG=0, go directly from IDLE to WAIT_TRIG.
  - TRIG is ignored in FILL.
- WAIT_TRIG:
  - Write each cycle.
  - On the first cycle with TRIG=1, the word written that cycle is the trigger sample: TRIG_ADDR <= wp, post-count <= DEPTH-PRETRIG-1, -> POST. If DEPTH-PRETRIG-1 = 0, go directly to DONE.
  - ARM is ignored while BUSY.
- POST:
  - Write each cycle; post-count--.
  - After the write that brings post-count to 0 -> DONE_ST: BUSY=0, DONE=1.
  - Further TRIG and ARM are ignored.
- DONE_ST:
  - No writes; input data is discarded.
  - RD_START -> READOUT.
  - ARM in DONE_ST is ignored; the data must be read first.
- READOUT:
  - Start sample address = (TRIG_ADDR - PRETRIG) mod DEPTH.
  - Word order: sample0 A, B, C, D; sample1 A, B, C, D; ... for 4*DEPTH words.
  - First DOUT_VALID is asserted 2 cycles after RD_START: RAM read plus output register.
  - DOUT and DOUT_LAST stay stable while DOUT_VALID=1 and DOUT_READY=0.
  - A word transfers when VALID and READY are both 1.
  - Sustained throughput is 1 word/cycle with READY held high. No word is dropped or duplicated under any READY pattern.
  - Address wraps mod DEPTH.
  - DOUT_LAST=1 only on word 4*DEPTH-1. After it transfers: DOUT_VALID=0, DONE=0 -> IDLE.
- Channel sample alignment: all four channels of one sample are written in the same RAM word in the same cycle. Inter-channel skew is 0 samples.

Test Plan (ADDR_W=4, DEPTH=16, PRETRIG=4; inputs are a counter, A=n, B=n+0x1000, C=n+0x2000, D=n+0x3000):
- ARM at n=10, TRIG at n=30 -> TRIG_ADDR=(slot of n=30). BUSY falls after n=41 is written. Readout is 64 words starting A=26 and ending D=0x3000+41, DOUT_LAST on word 63.
- TRIG held high from ARM (n=10) -> TRIG is ignored through FILL (n=10..13). The trigger sample is n=14, and readout starts at A=10.
- TRIG pulse during POST and ARM during DONE_ST -> no effect; TRIG_ADDR and the data window are unchanged.
- Readout with DOUT_READY toggling in a 1-0-0-1 pattern -> exactly 64 words in order, with DOUT held stable during stalls and no gaps or duplicates.
- RESET asserted mid-POST, then ARM/TRIG re-run -> after reset all outputs are 0. The new capture is correct, with no stale TRIG_ADDR.
- PRETRIG=0 and PRETRIG=15 builds -> the trigger sample is the first word / last sample (A of sample 15 = trigger). Write-pointer wrap is verified by ARM at n=5 and TRIG at n=100.
